// File: rtl/fifo_threshold_buf.sv
// fifo_threshold_buf
//
// Synchronous FIFO with programmable almost-empty / almost-full watermarks.
// One instance per buffered path (main FIFO, VC0, VC1, D0, D1). The
// flow-control FSM drives the thresholds and collects `empty` and `error`.
//
// Parameters
//   DATA_WIDTH  payload width (default 6)
//   DEPTH       number of entries, power of two, 2..16 (default 16)
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   wr_en         write request
//   data_in       write data
//   rd_en         read request
//   data_out      registered read data
//   valid_out     data_out holds a word popped on the previous cycle
//   thr_low       almost-empty threshold (live, not captured)
//   thr_high      almost-full threshold (live, not captured); 0 disables
//   count         current occupancy 0..DEPTH
//   empty         count == 0
//   full          count == DEPTH
//   almost_empty  count <= thr_low
//   almost_full   thr_high != 0 && count >= thr_high
//   error         sticky overflow/underflow flag, cleared only by reset
//
// Handshake: there is no back-pressure on the read side. A read accepted at
// edge N produces valid_out = 1 with its word on data_out for exactly the
// cycle following edge N. Requests that cannot be honoured (write while full
// without a read, read while empty) are dropped and raise error.

module fifo_threshold_buf #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [4:0]            thr_low,
  input  logic [4:0]            thr_high,
  output logic [4:0]            count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [4:0]      DEPTH_CNT = 5'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  logic wr_acc;
  logic rd_acc;
  logic overflow;
  logic underflow;

  assign empty = (count == 5'd0);
  assign full  = (count == DEPTH_CNT);

  // Watermarks use the registered count and the live thresholds, so a
  // threshold change is reflected in the same cycle.
  assign almost_full  = (thr_high != 5'd0) && (count >= thr_high);
  assign almost_empty = (count <= thr_low);

  always_comb begin
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    // At full a concurrent read frees the slot in the same edge, so the
    // write is still accepted. At empty the read has nothing to return.
    wr_acc    = wr_en && (!full || rd_en);
    rd_acc    = rd_en && !empty;
    overflow  = wr_en && full && !rd_en;
    underflow = rd_en && empty;
  end

  // Storage is not reset; pointers and count make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 5'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end

      if (rd_acc) begin
        data_out  <= mem[rd_ptr];
        rd_ptr    <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase

      if (overflow || underflow) begin
        error <= 1'b1;
      end
    end
  end

endmodule
